// File: rtl/cpu_datamem_arb.sv
// cpu_datamem_arb
// ---------------
// Round-robin arbiter in front of the CPU data memory. It replaces the old
// fixed 3-way host/cpu/accel priority mux. Each cycle at most one requestor
// is granted and its access is forwarded to the memory. Reads are tracked
// per channel so that the returned data can be tagged with its owner.
//
// Channel map: ch0 = host loader, ch1 = CPU, ch2.. = accelerators.
//
// Parameters:
//   NCH      number of requestor channels (2..8)
//   AW       address width
//   DW       write data width
//   RDW      memory read data width (broadcast to every channel)
//   MEM_LAT  memory read latency in cycles (1..4)
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req            per-channel request, held until granted
//   wrt_en         per-channel write(1)/read(0) qualifier, valid with req
//   addr           flattened addresses, channel i at [i*AW +: AW]
//   wrt_data       flattened write data, channel i at [i*DW +: DW]
//   gnt            one-hot grant; a transfer happens on req[i] & gnt[i]
//   rd_valid       one-hot pulse marking the owner of rd_data this cycle
//   rd_data        read data, broadcast (passed straight through)
//   mem_addr, mem_wrt_data, mem_wrt_en, mem_rd_en   memory request side
//   mem_rd_data    read data coming back from the memory
//
// Optional feature (macro DATAMEM_ARB_HOST_PRIO_EN):
//   When defined, ch0 (host) has strict priority and never moves the
//   round-robin pointer; rotation covers ch1..NCH-1 only. When undefined,
//   ch0 rotates like every other channel.

module cpu_datamem_arb #(
  parameter int NCH     = 3,
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int RDW     = 512,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    wrt_en,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wrt_data,
  output logic [NCH-1:0]    gnt,
  output logic [NCH-1:0]    rd_valid,
  output logic [RDW-1:0]    rd_data,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wrt_data,
  output logic              mem_wrt_en,
  output logic              mem_rd_en,
  input  logic [RDW-1:0]    mem_rd_data
);

  localparam int PW = $clog2(NCH);

  // Round-robin pointer: channel that gets first look next cycle.
  logic [PW-1:0] rrPtr_q;
  logic [PW-1:0] rrPtr_d;

  // Result of this cycle's arbitration.
  logic          granted;
  logic [PW-1:0] winIdx;

  // Read-return tracking pipeline: one {valid, id} entry per latency stage.
  logic [MEM_LAT-1:0] trkValid_q;
  logic [PW-1:0]      trkId_q [MEM_LAT];

  // Arbitration: scan channels starting at the pointer and take the first
  // one that is requesting. Reset forces "no grant" so nothing reaches the
  // memory while the block is being cleared.
  always_comb begin
    int cand;
    int start;
    granted = 1'b0;
    winIdx  = '0;
    cand    = 0;
    start   = 0;
`ifdef DATAMEM_ARB_HOST_PRIO_EN
    if (req[0]) begin
      granted = 1'b1;
      winIdx  = '0;
    end else begin
      // The pointer is 0 only straight after reset; rotation then starts at ch1.
      start = (rrPtr_q == '0) ? 1 : int'(rrPtr_q);
      for (int k = 0; k < NCH - 1; k++) begin
        cand = start + k;
        if (cand >= NCH) cand = cand - (NCH - 1);
        if (!granted && req[cand]) begin
          granted = 1'b1;
          winIdx  = PW'(cand);
        end
      end
    end
`else
    start = int'(rrPtr_q);
    for (int k = 0; k < NCH; k++) begin
      cand = start + k;
      if (cand >= NCH) cand = cand - NCH;
      if (!granted && req[cand]) begin
        granted = 1'b1;
        winIdx  = PW'(cand);
      end
    end
`endif
    if (rst) begin
      granted = 1'b0;
      winIdx  = '0;
    end
  end

  // One-hot grant and the memory request muxed from the winning channel.
  // With no grant every memory output is held at zero.
  always_comb begin
    gnt          = '0;
    mem_addr     = '0;
    mem_wrt_data = '0;
    mem_wrt_en   = 1'b0;
    mem_rd_en    = 1'b0;
    if (granted) begin
      gnt[winIdx]  = 1'b1;
      mem_addr     = addr[int'(winIdx)*AW +: AW];
      mem_wrt_data = wrt_data[int'(winIdx)*DW +: DW];
      mem_wrt_en   = wrt_en[winIdx];
      mem_rd_en    = ~wrt_en[winIdx];
    end
  end

  // Pointer update: move just past the winner, wrapping to the start of the
  // rotation. In host-priority mode a ch0 win leaves the pointer alone.
  always_comb begin
    rrPtr_d = rrPtr_q;
    if (granted) begin
`ifdef DATAMEM_ARB_HOST_PRIO_EN
      if (winIdx != '0) begin
        rrPtr_d = (winIdx == PW'(NCH - 1)) ? PW'(1) : winIdx + PW'(1);
      end
`else
      rrPtr_d = (winIdx == PW'(NCH - 1)) ? '0 : winIdx + PW'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr_q <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end

  // Tracking pipeline advances every cycle; stage 0 captures an accepted
  // read together with its owner. Reset empties it, dropping any reads still
  // in flight so their data is never announced.
  always_ff @(posedge clk) begin
    if (rst) begin
      trkValid_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        trkId_q[i] <= '0;
      end
    end else begin
      trkValid_q[0] <= mem_rd_en;
      trkId_q[0]    <= winIdx;
      for (int i = 1; i < MEM_LAT; i++) begin
        trkValid_q[i] <= trkValid_q[i-1];
        trkId_q[i]    <= trkId_q[i-1];
      end
    end
  end

  // The last stage lines up with the memory's data return. rd_valid is also
  // masked while reset is asserted.
  always_comb begin
    rd_valid = '0;
    if (trkValid_q[MEM_LAT-1] && !rst) begin
      rd_valid[trkId_q[MEM_LAT-1]] = 1'b1;
    end
  end

  assign rd_data = mem_rd_data;

endmodule

// File: tb/tb_cpu_datamem_arb.sv
// Testbench for cpu_datamem_arb. Two instances share the same stimulus: one
// with a 1-cycle memory and one with a 3-cycle memory, each backed by a small
// behavioural memory model. Inputs change on the falling edge; outputs are
// sampled 1 ns later.

module tb_cpu_datamem_arb;

  logic         clk;
  logic         rst;
  logic [2:0]   req;
  logic [2:0]   wrtEn;
  logic [47:0]  addr;
  logic [95:0]  wrtData;

  logic [2:0]   gnt1, rdValid1, gnt3, rdValid3;
  logic [511:0] rdData1, rdData3, memRdData1, memRdData3;
  logic [15:0]  memAddr1, memAddr3;
  logic [31:0]  memWrtData1, memWrtData3;
  logic         memWrtEn1, memRdEn1, memWrtEn3, memRdEn3;

  int testsRun;
  int failCount;

  cpu_datamem_arb #(.NCH(3), .AW(16), .DW(32), .RDW(512), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .wrt_en(wrtEn), .addr(addr),
    .wrt_data(wrtData), .gnt(gnt1), .rd_valid(rdValid1), .rd_data(rdData1),
    .mem_addr(memAddr1), .mem_wrt_data(memWrtData1), .mem_wrt_en(memWrtEn1),
    .mem_rd_en(memRdEn1), .mem_rd_data(memRdData1)
  );

  cpu_datamem_arb #(.NCH(3), .AW(16), .DW(32), .RDW(512), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req(req), .wrt_en(wrtEn), .addr(addr),
    .wrt_data(wrtData), .gnt(gnt3), .rd_valid(rdValid3), .rd_data(rdData3),
    .mem_addr(memAddr3), .mem_wrt_data(memWrtData3), .mem_wrt_en(memWrtEn3),
    .mem_rd_en(memRdEn3), .mem_rd_data(memRdData3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: unwritten words read back as A000_0000 | address.
  logic [31:0]  memArr [256];
  logic [255:0] wrote;

  function automatic logic [31:0] rdWord(input logic [15:0] a);
    return wrote[a[7:0]] ? memArr[a[7:0]] : (32'hA000_0000 | {16'h0, a});
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      wrote <= '0;
    end else if (memWrtEn1) begin
      wrote[memAddr1[7:0]]  <= 1'b1;
      memArr[memAddr1[7:0]] <= memWrtData1;
    end
  end

  logic [31:0] p1;
  logic        v1;
  always @(posedge clk) begin
    v1 <= memRdEn1;
    p1 <= rdWord(memAddr1);
  end
  assign memRdData1 = v1 ? {480'b0, p1} : '0;

  logic [31:0] p3 [3];
  logic [2:0]  v3;
  always @(posedge clk) begin
    v3    <= {v3[1:0], memRdEn3};
    p3[0] <= rdWord(memAddr3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign memRdData3 = v3[2] ? {480'b0, p3[2]} : '0;

  // One cycle of stimulus: drive at the falling edge, settle, then return.
  task automatic applyStimulus(input logic r, input logic [2:0] rq, input logic [2:0] we);
    @(negedge clk);
    rst   = r;
    req   = rq;
    wrtEn = we;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkData(input string name, input logic [511:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== {480'b0, exp}) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  expGnt;
    logic        expRdEn;
    logic [15:0] expAddr;
    logic [2:0]  expRv1;
    logic [31:0] expData1;
    logic [2:0]  expRv3;
    logic [31:0] expData3;
  } vec_t;

  vec_t vecs [9];
  logic [2:0] seenRv1;
  logic [2:0] seenRv3;

  initial begin
    testsRun  = 0;
    failCount = 0;
    rst     = 1'b1;
    req     = '0;
    wrtEn   = '0;
    addr    = {16'h0024, 16'h0040, 16'h0008};
    wrtData = '0;

    // Rotation with all three reading, continuing right after the single
    // CPU read (pointer sits at 2, so ch2 goes first).
    vecs[0] = '{3'b000, 3'b000, 1'b0, 16'h0000, 3'b010, 32'hA000_0040, 3'b000, 32'h0};
    vecs[1] = '{3'b111, 3'b100, 1'b1, 16'h0024, 3'b000, 32'h0,          3'b000, 32'h0};
    vecs[2] = '{3'b111, 3'b001, 1'b1, 16'h0008, 3'b100, 32'hA000_0024, 3'b010, 32'hA000_0040};
    vecs[3] = '{3'b111, 3'b010, 1'b1, 16'h0040, 3'b001, 32'hA000_0008, 3'b000, 32'h0};
    vecs[4] = '{3'b111, 3'b100, 1'b1, 16'h0024, 3'b010, 32'hA000_0040, 3'b100, 32'hA000_0024};
    vecs[5] = '{3'b000, 3'b000, 1'b0, 16'h0000, 3'b100, 32'hA000_0024, 3'b001, 32'hA000_0008};
    vecs[6] = '{3'b000, 3'b000, 1'b0, 16'h0000, 3'b000, 32'h0,          3'b010, 32'hA000_0040};
    vecs[7] = '{3'b000, 3'b000, 1'b0, 16'h0000, 3'b000, 32'h0,          3'b100, 32'hA000_0024};
    vecs[8] = '{3'b000, 3'b000, 1'b0, 16'h0000, 3'b000, 32'h0,          3'b000, 32'h0};

    // Reset with everyone requesting: nothing may be granted.
    applyStimulus(1'b1, 3'b111, 3'b000);
    checkOutput("rst_gnt", {61'b0, gnt1}, 64'h0);
    checkOutput("rst_mem_en", {62'b0, memRdEn1, memWrtEn1}, 64'h0);
    applyStimulus(1'b1, 3'b000, 3'b000);
    checkOutput("rst_rd_valid", {61'b0, rdValid1}, 64'h0);

    // Single CPU read.
    applyStimulus(1'b0, 3'b010, 3'b000);
    checkOutput("cpu_rd_gnt", {61'b0, gnt1}, 64'h2);
    checkOutput("cpu_rd_en", {62'b0, memRdEn1, memWrtEn1}, 64'h2);
    checkOutput("cpu_rd_addr", {48'b0, memAddr1}, 64'h0040);

`ifndef DATAMEM_ARB_HOST_PRIO_EN
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, vecs[i].req, 3'b000);
      checkOutput($sformatf("vec%0d_gnt1", i), {61'b0, gnt1}, {61'b0, vecs[i].expGnt});
      checkOutput($sformatf("vec%0d_gnt3", i), {61'b0, gnt3}, {61'b0, vecs[i].expGnt});
      checkOutput($sformatf("vec%0d_rd_en", i), {63'b0, memRdEn1}, {63'b0, vecs[i].expRdEn});
      checkOutput($sformatf("vec%0d_addr", i), {48'b0, memAddr1}, {48'b0, vecs[i].expAddr});
      checkOutput($sformatf("vec%0d_rv1", i), {61'b0, rdValid1}, {61'b0, vecs[i].expRv1});
      checkData($sformatf("vec%0d_data1", i), rdData1, vecs[i].expData1);
      checkOutput($sformatf("vec%0d_rv3", i), {61'b0, rdValid3}, {61'b0, vecs[i].expRv3});
      checkData($sformatf("vec%0d_data3", i), rdData3, vecs[i].expData3);
    end
`endif

    // Write by ch2 followed by a read of the same address by ch1.
    applyStimulus(1'b0, 3'b000, 3'b000);
    addr    = {16'h0010, 16'h0010, 16'h0008};
    wrtData = {32'hDEAD_BEEF, 32'h0, 32'h0};
    applyStimulus(1'b0, 3'b100, 3'b100);
    checkOutput("wr_gnt", {61'b0, gnt1}, 64'h4);
    checkOutput("wr_en", {62'b0, memRdEn1, memWrtEn1}, 64'h1);
    checkOutput("wr_addr", {48'b0, memAddr1}, 64'h0010);
    checkOutput("wr_data", {32'b0, memWrtData1}, 64'hDEAD_BEEF);
    applyStimulus(1'b0, 3'b010, 3'b000);
    checkOutput("rd_after_wr_gnt", {61'b0, gnt1}, 64'h2);
    applyStimulus(1'b0, 3'b000, 3'b000);
    checkOutput("rd_after_wr_rv1", {61'b0, rdValid1}, 64'h2);
    checkData("rd_after_wr_data1", rdData1, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 3'b000, 3'b000);
    applyStimulus(1'b0, 3'b000, 3'b000);
    checkOutput("rd_after_wr_rv3", {61'b0, rdValid3}, 64'h2);
    checkData("rd_after_wr_data3", rdData3, 32'hDEAD_BEEF);

    // Reset in the middle of three outstanding 3-cycle reads.
    addr = {16'h0024, 16'h0040, 16'h0008};
    applyStimulus(1'b1, 3'b000, 3'b000);
    applyStimulus(1'b1, 3'b000, 3'b000);
    applyStimulus(1'b0, 3'b010, 3'b000);
    checkOutput("mid_gnt_a", {61'b0, gnt3}, 64'h2);
    applyStimulus(1'b0, 3'b100, 3'b000);
    checkOutput("mid_gnt_b", {61'b0, gnt3}, 64'h4);
    applyStimulus(1'b0, 3'b010, 3'b000);
    checkOutput("mid_gnt_c", {61'b0, gnt3}, 64'h2);
    applyStimulus(1'b1, 3'b111, 3'b000);
    checkOutput("mid_rst_gnt", {61'b0, gnt3}, 64'h0);
    checkOutput("mid_rst_mem_en", {62'b0, memRdEn3, memWrtEn3}, 64'h0);
    seenRv3 = '0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 3'b000, 3'b000);
      seenRv3 |= rdValid3;
    end
    checkOutput("mid_rst_no_rv3", {61'b0, seenRv3}, 64'h0);
    applyStimulus(1'b0, 3'b111, 3'b000);
    checkOutput("mid_rst_ptr0", {61'b0, gnt3}, 64'h1);

    // ch2 requests for one cycle while ch1 wins, then withdraws.
    applyStimulus(1'b1, 3'b000, 3'b000);
    applyStimulus(1'b0, 3'b110, 3'b000);
    checkOutput("wd_gnt", {61'b0, gnt1}, 64'h2);
    applyStimulus(1'b0, 3'b000, 3'b000);
    checkOutput("wd_no_access", {59'b0, gnt1, memRdEn1, memWrtEn1}, 64'h0);
    checkOutput("wd_rv1_ch1", {61'b0, rdValid1}, 64'h2);
    seenRv1 = '0;
    seenRv3 = '0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 3'b000, 3'b000);
      seenRv1 |= rdValid1;
      seenRv3 |= rdValid3;
    end
    checkOutput("wd_rv1_tail", {61'b0, seenRv1}, 64'h0);
    checkOutput("wd_rv3_seen", {61'b0, seenRv3}, 64'h2);

    // Host priority versus plain rotation.
    applyStimulus(1'b1, 3'b000, 3'b000);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 3'b111, 3'b000);
`ifdef DATAMEM_ARB_HOST_PRIO_EN
      checkOutput($sformatf("prio_all_%0d", i), {61'b0, gnt1}, 64'h1);
`else
      checkOutput($sformatf("rr_all_%0d", i), {61'b0, gnt1}, 64'h1 << (i % 3));
`endif
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 3'b110, 3'b000);
      checkOutput($sformatf("rr_no_host_%0d", i), {61'b0, gnt1}, (i % 2 == 0) ? 64'h2 : 64'h4);
    end

    applyStimulus(1'b0, 3'b000, 3'b000);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
